// File: rtl/hilo_mdu_ctrl.sv
// HI/LO owner for EX: single-cycle MULT/MULTU/MTHI/MTLO, MFHI/MFLO read-out,
// and a 32-step restoring divider that stalls the pipeline. Optional: MDU_DIV_ZERO_FLAG_EN.

`ifndef MULT_CONTROL
`define MULT_CONTROL  5'b01101
`endif
`ifndef MULTU_CONTROL
`define MULTU_CONTROL 5'b01110
`endif
`ifndef DIV_CONTROL
`define DIV_CONTROL   5'b01111
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL  5'b10000
`endif
`ifndef MFHI_CONTROL
`define MFHI_CONTROL  5'b10001
`endif
`ifndef MFLO_CONTROL
`define MFLO_CONTROL  5'b10010
`endif
`ifndef MTHI_CONTROL
`define MTHI_CONTROL  5'b10011
`endif
`ifndef MTLO_CONTROL
`define MTLO_CONTROL  5'b10100
`endif

module hilo_mdu_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  alucontrol,
    input  logic        op_valid,
    input  logic        flush,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stall,
    output logic [31:0] hilo_rdata,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
`ifdef MDU_DIV_ZERO_FLAG_EN
    ,
    output logic        div_zero
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_n;
    logic [5:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo, divisor;
    logic        qsign, rsign;
    logic [31:0] hi, lo;

    logic        go, is_div, is_signed_div, start_div;
    logic [31:0] mag_a, mag_b;
    logic [33:0] trial;
    logic [32:0] shifted;
    logic [31:0] quo_fix, rem_fix;
    logic        suppress_wr;
    logic signed [63:0] prod_s;
    logic [63:0] prod_u;

    assign go            = op_valid & ~flush;
    assign is_signed_div = (alucontrol == `DIV_CONTROL);
    assign is_div        = is_signed_div | (alucontrol == `DIVU_CONTROL);
    assign start_div     = (state == IDLE) & go & is_div;

    assign mag_a = (is_signed_div & src_a[31]) ? -src_a : src_a;
    assign mag_b = (is_signed_div & src_b[31]) ? -src_b : src_b;

    // One restoring step: the 34-bit trial keeps the borrow out of the 33-bit remainder.
    assign shifted = {rem[31:0], quo[31]};
    assign trial   = {rem, quo[31]} - {2'b00, divisor};

    assign quo_fix = qsign ? -quo : quo;
    assign rem_fix = rsign ? -rem[31:0] : rem[31:0];

    assign prod_s = $signed(src_a) * $signed(src_b);
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_n = state;
        stall   = 1'b0;
        case (state)
            IDLE: if (start_div) begin
                state_n = BUSY;
                stall   = 1'b1;
            end
            BUSY: if (flush) begin
                state_n = IDLE;
            end else begin
                stall = 1'b1;
                if (cnt == 6'd31) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            qsign   <= 1'b0;
            rsign   <= 1'b0;
        end else if (start_div) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= mag_a;
            divisor <= mag_b;
            qsign   <= is_signed_div & (src_a[31] ^ src_b[31]);
            rsign   <= is_signed_div & src_a[31];
        end else if (flush) begin
            cnt <= '0;
        end else if (state == BUSY) begin
            cnt <= cnt + 6'd1;
            if (trial[33]) begin
                rem <= shifted;
                quo <= {quo[30:0], 1'b0};
            end else begin
                rem <= trial[32:0];
                quo <= {quo[30:0], 1'b1};
            end
        end
    end

`ifdef MDU_DIV_ZERO_FLAG_EN
    logic dz;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)        dz <= 1'b0;
        else if (start_div) dz <= (src_b == 32'd0);
    end

    assign div_zero    = (state == DONE) & dz;
    assign suppress_wr = dz;
`else
    assign suppress_wr = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if ((state == IDLE) & go) begin
            case (alucontrol)
                `MULT_CONTROL:  {hi, lo} <= prod_s;
                `MULTU_CONTROL: {hi, lo} <= prod_u;
                `MTHI_CONTROL:  hi <= src_a;
                `MTLO_CONTROL:  lo <= src_a;
                default: ;
            endcase
        end else if ((state == DONE) & ~flush & ~suppress_wr) begin
            lo <= quo_fix;
            hi <= rem_fix;
        end
    end

    always_comb begin
        hilo_rdata = 32'd0;
        if (alucontrol == `MFHI_CONTROL)      hilo_rdata = hi;
        else if (alucontrol == `MFLO_CONTROL) hilo_rdata = lo;
    end

    assign hi_o = hi;
    assign lo_o = lo;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed bench for hilo_mdu_ctrl: multiplies, MT/MF, divides, flush, async reset
// and divide-by-zero in both MDU_DIV_ZERO_FLAG_EN builds.

`ifndef MULT_CONTROL
`define MULT_CONTROL  5'b01101
`endif
`ifndef MULTU_CONTROL
`define MULTU_CONTROL 5'b01110
`endif
`ifndef DIV_CONTROL
`define DIV_CONTROL   5'b01111
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL  5'b10000
`endif
`ifndef MFHI_CONTROL
`define MFHI_CONTROL  5'b10001
`endif
`ifndef MFLO_CONTROL
`define MFLO_CONTROL  5'b10010
`endif
`ifndef MTHI_CONTROL
`define MTHI_CONTROL  5'b10011
`endif
`ifndef MTLO_CONTROL
`define MTLO_CONTROL  5'b10100
`endif

module tb_hilo_mdu_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  alucontrol;
    logic        op_valid;
    logic        flush;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stall;
    logic [31:0] hilo_rdata;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
`ifdef MDU_DIV_ZERO_FLAG_EN
    logic        div_zero;
`endif

    int total = 0;
    int bad   = 0;

    hilo_mdu_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .alucontrol (alucontrol),
        .op_valid   (op_valid),
        .flush      (flush),
        .src_a      (src_a),
        .src_b      (src_b),
        .stall      (stall),
        .hilo_rdata (hilo_rdata),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
`ifdef MDU_DIV_ZERO_FLAG_EN
        ,
        .div_zero   (div_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a divide, counts stall cycles (scrambling operands during BUSY),
    // then checks the DONE cycle and the HI/LO result after it.
    task automatic run_div(input string tag, input logic [4:0] code,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input logic exp_dz);
        int n;
        alucontrol = code;
        src_a      = a;
        src_b      = b;
        op_valid   = 1'b1;
        flush      = 1'b0;
        n          = 0;
        #1;
        while (stall && n < 50) begin
            n++;
            tick();
            src_a = $urandom;
            src_b = $urandom;
            #1;
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'd33);
`ifdef MDU_DIV_ZERO_FLAG_EN
        check({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
`else
        check({tag, "_dz_unused"}, {31'd0, exp_dz}, 32'd0);
`endif
        tick();
        op_valid   = 1'b0;
        alucontrol = 5'd0;
        #1;
        check({tag, "_lo"}, lo_o, exp_lo);
        check({tag, "_hi"}, hi_o, exp_hi);
`ifdef MDU_DIV_ZERO_FLAG_EN
        check({tag, "_div_zero_after"}, {31'd0, div_zero}, 32'd0);
`endif
    endtask

    initial begin
        resetn     = 1'b0;
        alucontrol = 5'd0;
        op_valid   = 1'b0;
        flush      = 1'b0;
        src_a      = 32'd0;
        src_b      = 32'd0;
        #23;
        check("reset_hi", hi_o, 32'd0);
        check("reset_lo", lo_o, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_rdata", hilo_rdata, 32'd0);
        resetn = 1'b1;
        tick();

        // Signed and unsigned multiply of the same operands.
        alucontrol = `MULT_CONTROL; src_a = 32'hFFFF_FFFF; src_b = 32'h0000_0002; op_valid = 1'b1;
        #1;
        check("mult_stall", {31'd0, stall}, 32'd0);
        tick();
        check("mult_hi", hi_o, 32'hFFFF_FFFF);
        check("mult_lo", lo_o, 32'hFFFF_FFFE);
        alucontrol = `MULTU_CONTROL;
        #1;
        check("multu_stall", {31'd0, stall}, 32'd0);
        tick();
        check("multu_hi", hi_o, 32'h0000_0001);
        check("multu_lo", lo_o, 32'hFFFF_FFFE);
        op_valid = 1'b0;

        run_div("divu_100_7", `DIVU_CONTROL, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        alucontrol = `MFLO_CONTROL; op_valid = 1'b1;
        #1;
        check("mflo_after_div", hilo_rdata, 32'd14);
        alucontrol = `MFHI_CONTROL;
        #1;
        check("mfhi_after_div", hilo_rdata, 32'd2);
        op_valid = 1'b0; alucontrol = 5'd0;
        tick();

        run_div("div_m7_2", `DIV_CONTROL, 32'hFFFF_FFF9, 32'h0000_0002,
                32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_div("div_7_m2", `DIV_CONTROL, 32'h0000_0007, 32'hFFFF_FFFE,
                32'hFFFF_FFFD, 32'h0000_0001, 1'b0);

        // Flush on BUSY cycle 10: stall drops at once, HI/LO keep 1 / 0xFFFFFFFD.
        alucontrol = `DIVU_CONTROL; src_a = 32'd100; src_b = 32'd7; op_valid = 1'b1;
        #1;
        check("flush_entry_stall", {31'd0, stall}, 32'd1);
        tick();
        for (int i = 0; i < 9; i++) tick();
        check("flush_busy10_stall", {31'd0, stall}, 32'd1);
        flush = 1'b1;
        #1;
        check("flush_stall_drop", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0; op_valid = 1'b0;
        #1;
        check("flush_idle", {31'd0, stall}, 32'd0);
        for (int i = 0; i < 40; i++) tick();
        check("flush_hi_kept", hi_o, 32'h0000_0001);
        check("flush_lo_kept", lo_o, 32'hFFFF_FFFD);
        run_div("divu_after_flush", `DIVU_CONTROL, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        // MTHI/MTLO visible to MF in the following cycle.
        alucontrol = `MTHI_CONTROL; src_a = 32'h1234_5678; op_valid = 1'b1;
        tick();
        alucontrol = `MFHI_CONTROL;
        #1;
        check("mthi_mfhi", hilo_rdata, 32'h1234_5678);
        alucontrol = `MTLO_CONTROL; src_a = 32'h0BAD_F00D;
        tick();
        alucontrol = `MFLO_CONTROL;
        #1;
        check("mtlo_mflo", hilo_rdata, 32'h0BAD_F00D);

        // Async reset in the middle of a divide.
        alucontrol = `DIVU_CONTROL; src_a = 32'd100; src_b = 32'd7;
        tick();
        for (int i = 0; i < 5; i++) tick();
        #2;
        resetn = 1'b0; op_valid = 1'b0;
        #1;
        check("rst_mid_hi", hi_o, 32'd0);
        check("rst_mid_lo", lo_o, 32'd0);
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        check("rst_release_hi", hi_o, 32'd0);

        // Divide by zero, with known prior HI/LO.
        alucontrol = `MTHI_CONTROL; src_a = 32'hAAAA_0001; op_valid = 1'b1;
        tick();
        alucontrol = `MTLO_CONTROL; src_a = 32'h5555_0002;
        tick();
        op_valid = 1'b0;
`ifdef MDU_DIV_ZERO_FLAG_EN
        run_div("divu_5_0", `DIVU_CONTROL, 32'd5, 32'd0, 32'h5555_0002, 32'hAAAA_0001, 1'b1);
`else
        run_div("divu_5_0", `DIVU_CONTROL, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
